bfly_net_iter: RTL and testbench
================================

Name: bfly_net_iter

Overview:
- Iterative 32-bit butterfly / inverse-butterfly permutation datapath. It consumes the five 16-bit switch-configuration words produced by the bit-manipulation config generator.
- Executes one network stage per clock.
- EXT (extract, pext-style): applies the mask to the data, then runs the inverse butterfly.
- DEP (deposit, pdep-style): runs the butterfly, then applies the mask.
- Sits in the bit-manipulation unit between the configuration generator and the result writeback. Uses a valid/ready request/response handshake.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- NSTG, 5, number of network stages (log2 XLEN).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  block can accept a request
- req_op_i  input  1  0 = EXT, 1 = DEP
- req_data_i  input  32  source operand
- req_mask_i  input  32  mask operand
- req_cfg0_i..req_cfg4_i  input  16 each  switch config for stage distances 1, 2, 4, 8, 16
- kill_i  input  1  abort any in-flight operation
- resp_valid_o  output  1  result valid
- resp_ready_i  input  1  consumer accepts result
- resp_data_o  output  32  permuted result

Behaviour:
- Reset: asynchronous and active-low, one clock domain.
  - State is IDLE.
  - req_ready_o = 1, resp_valid_o = 0, resp_data_o = 0.
  - Internal data, cfg, mask, op and stage counter all clear to 0.
- Switch semantics for a stage of distance d:
  - Pairs are (i, i+d) for every i with bit log2(d) of i equal to 0.
  - Switch index k = (i/(2d))*d + (i mod d).
  - cfg bit k = 1: straight. cfg bit k = 0: swap the two bits.
- Stage order:
  - EXT (inverse butterfly): d = 1, 2, 4, 8, 16, using cfg0..cfg4.
  - DEP (butterfly): d = 16, 8, 4, 2, 1, using cfg4..cfg0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: req_ready_o = 1. On req_valid_i & req_ready_o:
    - Capture op, cfg and mask.
    - Load data as req_data_i & req_mask_i for EXT, or req_data_i for DEP.
    - Set stg = 0 and go to RUN.
  - RUN: each edge applies stage stg (in the order for the captured op) and increments stg. req_ready_o = 0.
    - On the edge applying the last stage (stg = 4), go to DONE.
    - For DEP, that same edge ANDs the result with the captured mask.
  - DONE: resp_valid_o = 1 and resp_data_o holds the result.
    - On resp_ready_i, go to IDLE with resp_valid_o = 0.
    - No new request is accepted in the same cycle as the response handshake; req_ready_o rises the next cycle.
- Latency: acceptance edge T; resp_valid_o = 1 in the cycle after edge T+5. Throughput is one operation per at least 7 cycles.
- Backpressure: while resp_ready_i = 0 in DONE, resp_data_o and resp_valid_o stay stable indefinitely.
- kill_i:
  - Synchronous, highest priority in every state: next state is IDLE and resp_valid_o = 0 next cycle.
  - A request presented in the same cycle as kill_i is not accepted.
- stg is 3 bits. Values 5–7 are unreachable; the stage mux treats them as straight (no change).
- Request inputs are sampled only at acceptance; later changes are ignored.
- Reset asserted mid-RUN or mid-DONE immediately returns the block to its reset values.

Decomposition:
- Shared package bmu_pkg:
  - XLEN and NSTG constants.
  - bmu_op_e enum (BMU_EXT, BMU_DEP).
  - bfly_state_e enum (IDLE, RUN, DONE).
  - Function mapping (op, stg) to the stage distance exponent.
- Sub-module bfly_stage_mux: combinational single stage taking 32-bit data, 16-bit cfg and a 3-bit distance exponent. Instantiated once and reused every cycle.

Test Plan:
- Identity: all cfg = 16'hFFFF, mask 32'hFFFFFFFF, data 32'hDEADBEEF, EXT and DEP -> resp_data_o = 32'hDEADBEEF; resp_valid_o rises in the cycle after edge T+5.
- Ordering: cfg0 = cfg4 = 16'hFFFE, others 16'hFFFF, mask all ones, data 32'h1.
  - EXT -> 32'h00000002.
  - DEP -> 32'h00010000.
- Full stage swap: cfg4 = 16'h0000, others 16'hFFFF, data 32'h0000FFFF, mask all ones -> 32'hFFFF0000 for both ops.
- Mask placement: identity cfg, data 32'hF.
  - EXT with mask 32'hE -> 32'hE.
  - DEP with mask 32'h1 -> 32'h1.
  - DEP with cfg0 = 16'hFFFE, mask 32'h1, data 32'h2 -> 32'h1 (mask applied after the network).
- Backpressure: hold resp_ready_i = 0 for 3 cycles in DONE -> resp_data_o stable, req_ready_o = 0, a pending req_valid_i is not accepted; accepted in the cycle after the response handshake.
- Abort and reset:
  - kill_i at RUN stg = 2 -> IDLE next cycle, no resp_valid_o, next request completes normally.
  - rst_n low mid-DONE -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/bmu_pkg.sv
// Shared types and constants for the bit-manipulation unit's butterfly datapath.
// Maps the stage counter to a network distance exponent for either op.
package bmu_pkg;

  localparam int XLEN = 32;
  localparam int NSTG = 5;

  typedef enum logic {
    BMU_EXT = 1'b0,
    BMU_DEP = 1'b1
  } bmu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bfly_state_e;

  // EXT walks distances 1..16, DEP walks 16..1; counts past the last stage give
  // an exponent the stage mux treats as straight.
  function automatic logic [2:0] stage_exp(input bmu_op_e op, input logic [2:0] stg);
    if (stg >= 3'(NSTG)) return 3'(NSTG);
    return (op == BMU_EXT) ? stg : 3'(NSTG - 1) - stg;
  endfunction

endpackage

// File: rtl/bfly_stage_mux.sv
// One butterfly network stage at distance 2**dist_exp_i; cfg bit 1 = straight, 0 = swap.
// Exponents outside 0..4 pass the data through unchanged.
module bfly_stage_mux
  import bmu_pkg::*;
(
  input  logic [XLEN-1:0] data_i,
  input  logic [15:0]     cfg_i,
  input  logic [2:0]      dist_exp_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    data_o = data_i;
    for (int e = 0; e < NSTG; e++) begin
      if (dist_exp_i == 3'(e)) begin
        for (int i = 0; i < XLEN; i++) begin
          // Lower member of each pair has bit e clear; switch k numbers pairs densely.
          if (((i >> e) & 1) == 0) begin
            if (!cfg_i[(i >> (e + 1)) * (1 << e) + (i % (1 << e))]) begin
              data_o[i]            = data_i[i + (1 << e)];
              data_o[i + (1 << e)] = data_i[i];
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/bfly_net_iter.sv
// Iterative butterfly / inverse-butterfly permutation: one stage per clock,
// EXT masks before the inverse butterfly, DEP masks after the butterfly.
module bfly_net_iter
  import bmu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_op_i,
  input  logic [XLEN-1:0] req_data_i,
  input  logic [XLEN-1:0] req_mask_i,
  input  logic [15:0]     req_cfg0_i,
  input  logic [15:0]     req_cfg1_i,
  input  logic [15:0]     req_cfg2_i,
  input  logic [15:0]     req_cfg3_i,
  input  logic [15:0]     req_cfg4_i,
  input  logic            kill_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_data_o
);

  bfly_state_e           state_q, state_d;
  bmu_op_e               op_q;
  logic [XLEN-1:0]       data_q, mask_q;
  logic [NSTG-1:0][15:0] cfg_q;
  logic [2:0]            stg_q;

  logic [2:0]      dist_exp;
  logic [15:0]     cfg_sel;
  logic [XLEN-1:0] stage_out;
  logic            accept, last_stg;

  assign accept   = (state_q == IDLE) && req_valid_i && !kill_i;
  assign last_stg = (stg_q == 3'(NSTG - 1));
  assign dist_exp = stage_exp(op_q, stg_q);

  always_comb begin
    cfg_sel = '1;
    case (dist_exp)
      3'd0: cfg_sel = cfg_q[0];
      3'd1: cfg_sel = cfg_q[1];
      3'd2: cfg_sel = cfg_q[2];
      3'd3: cfg_sel = cfg_q[3];
      3'd4: cfg_sel = cfg_q[4];
      default: cfg_sel = '1;
    endcase
  end

  bfly_stage_mux u_stage (
    .data_i     (data_q),
    .cfg_i      (cfg_sel),
    .dist_exp_i (dist_exp),
    .data_o     (stage_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_stg) state_d = DONE;
      DONE:    if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign resp_data_o  = (state_q == DONE) ? data_q : '0;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every datapath register is reset, so a reset mid-operation leaves no
  // stale operand or counter behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= BMU_EXT;
      data_q <= '0;
      mask_q <= '0;
      cfg_q  <= '0;
      stg_q  <= '0;
    end else if (accept) begin
      op_q   <= bmu_op_e'(req_op_i);
      data_q <= req_op_i ? req_data_i : (req_data_i & req_mask_i);
      mask_q <= req_mask_i;
      cfg_q  <= {req_cfg4_i, req_cfg3_i, req_cfg2_i, req_cfg1_i, req_cfg0_i};
      stg_q  <= '0;
    end else if (state_q == RUN && !kill_i) begin
      data_q <= (op_q == BMU_DEP && last_stg) ? (stage_out & mask_q) : stage_out;
      stg_q  <= stg_q + 3'd1;
    end
  end

endmodule

// File: tb/tb_bfly_net_iter.sv
// Directed bench for bfly_net_iter: permutation vectors, latency, backpressure,
// kill and asynchronous reset.
module tb_bfly_net_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o, req_op_i;
  logic [31:0] req_data_i, req_mask_i;
  logic [15:0] req_cfg0_i, req_cfg1_i, req_cfg2_i, req_cfg3_i, req_cfg4_i;
  logic        kill_i, resp_valid_o, resp_ready_i;
  logic [31:0] resp_data_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] cfg_v[5];

  localparam logic EXT = 1'b0;
  localparam logic DEP = 1'b1;

  always #5 clk = ~clk;

  bfly_net_iter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_data_i   (req_data_i),
    .req_mask_i   (req_mask_i),
    .req_cfg0_i   (req_cfg0_i),
    .req_cfg1_i   (req_cfg1_i),
    .req_cfg2_i   (req_cfg2_i),
    .req_cfg3_i   (req_cfg3_i),
    .req_cfg4_i   (req_cfg4_i),
    .kill_i       (kill_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o)
  );

  task automatic set_cfg(input logic [15:0] c0, c1, c2, c3, c4);
    cfg_v[0] = c0; cfg_v[1] = c1; cfg_v[2] = c2; cfg_v[3] = c3; cfg_v[4] = c4;
  endtask

  task automatic drive_req(input logic op, input logic [31:0] data, mask);
    req_op_i = op; req_data_i = data; req_mask_i = mask;
    req_cfg0_i = cfg_v[0]; req_cfg1_i = cfg_v[1]; req_cfg2_i = cfg_v[2];
    req_cfg3_i = cfg_v[3]; req_cfg4_i = cfg_v[4];
    req_valid_i = 1'b1;
  endtask

  // Drops valid and scrambles every request input after acceptance.
  task automatic scramble_req();
    req_valid_i = 1'b0;
    req_op_i = ~req_op_i; req_data_i = ~req_data_i; req_mask_i = ~req_mask_i;
    req_cfg0_i = ~req_cfg0_i; req_cfg1_i = ~req_cfg1_i; req_cfg2_i = ~req_cfg2_i;
    req_cfg3_i = ~req_cfg3_i; req_cfg4_i = ~req_cfg4_i;
  endtask

  task automatic start_op(input logic op, input logic [31:0] data, mask, input string name);
    @(negedge clk);
    drive_req(op, data, mask);
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s req_ready: got %b want 1", name, req_ready_o);
    end
    @(posedge clk);
    #1 scramble_req();
  endtask

  // Counts negedges after the acceptance edge until resp_valid_o; expects 6.
  task automatic wait_valid(input string name);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (resp_valid_o !== 1'b1 && lat < 20);
    n_checks++;
    if (lat != 6) begin
      n_fail++;
      $display("FAIL %s latency: got %0d negedges want 6", name, lat);
    end
  endtask

  task automatic check_data(input logic [31:0] expv, input string name);
    n_checks++;
    if (resp_data_o !== expv) begin
      n_fail++;
      $display("FAIL %s data: got %h want %h", name, resp_data_o, expv);
    end
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1 resp_ready_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after handshake: valid %b ready %b want 0 1", name, resp_valid_o, req_ready_o);
    end
  endtask

  task automatic run_op(input logic op, input logic [31:0] data, mask, expv, input string name);
    start_op(op, data, mask, name);
    wait_valid(name);
    check_data(expv, name);
    handshake(name);
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL %s reset outputs: ready %b valid %b data %h want 1 0 00000000",
               name, req_ready_o, resp_valid_o, resp_data_o);
    end
  endtask

  task automatic test_reset();
    #2 check_reset_outputs("reset_asserted");
    #20 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_released");
  endtask

  task automatic test_identity();
    set_cfg(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_op(EXT, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF, "identity_ext");
    run_op(DEP, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF, "identity_dep");
  endtask

  task automatic test_ordering();
    set_cfg(16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE);
    run_op(EXT, 32'h1, 32'hFFFFFFFF, 32'h00000002, "order_ext");
    run_op(DEP, 32'h1, 32'hFFFFFFFF, 32'h00010000, "order_dep");
  endtask

  task automatic test_full_swap();
    set_cfg(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000);
    run_op(EXT, 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFF0000, "swap_ext");
    run_op(DEP, 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFF0000, "swap_dep");
  endtask

  // Single-switch swaps at non-zero switch indices in stages d=2 and d=8.
  task automatic test_switch_index();
    set_cfg(16'hFFFF, 16'hFFFD, 16'hFFFF, 16'hFDFF, 16'hFFFF);
    run_op(EXT, 32'h00020002, 32'hFFFFFFFF, 32'h02000008, "index_ext");
    run_op(DEP, 32'h00020002, 32'hFFFFFFFF, 32'h02000008, "index_dep");
  endtask

  task automatic test_mask();
    set_cfg(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_op(EXT, 32'hF, 32'hE, 32'hE, "mask_ext");
    run_op(DEP, 32'hF, 32'h1, 32'h1, "mask_dep");
    set_cfg(16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_op(DEP, 32'h2, 32'h1, 32'h1, "mask_dep_after_net");
  endtask

  task automatic test_backpressure();
    set_cfg(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    start_op(DEP, 32'h12345678, 32'hFFFFFFFF, "bp_first");
    wait_valid("bp_first");
    drive_req(EXT, 32'hF, 32'hE);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (resp_valid_o !== 1'b1 || resp_data_o !== 32'h12345678 || req_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: valid %b data %h ready %b want 1 12345678 0",
                 c, resp_valid_o, resp_data_o, req_ready_o);
      end
    end
    resp_ready_i = 1'b1;
    @(posedge clk);
    #1 resp_ready_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: ready %b valid %b want 1 0", req_ready_o, resp_valid_o);
    end
    @(posedge clk);
    #1 scramble_req();
    wait_valid("bp_second");
    check_data(32'hE, "bp_second");
    handshake("bp_second");
  endtask

  task automatic test_kill();
    bit seen = 1'b0;
    set_cfg(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    start_op(EXT, 32'hA5A5A5A5, 32'hFFFFFFFF, "kill_run");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    kill_i = 1'b1;
    @(posedge clk);
    #1 kill_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_run: ready %b valid %b want 1 0", req_ready_o, resp_valid_o);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid_o !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL kill_no_resp: resp_valid seen 1 want 0");
    end
    drive_req(DEP, 32'h1, 32'hFFFFFFFF);
    kill_i = 1'b1;
    @(posedge clk);
    #1 kill_i = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_idle_req: ready %b want 1", req_ready_o);
    end
    set_cfg(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000);
    run_op(EXT, 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFF0000, "kill_then_normal");
  endtask

  task automatic test_reset_mid_done();
    set_cfg(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    start_op(EXT, 32'hCAFEF00D, 32'hFFFFFFFF, "rst_done");
    wait_valid("rst_done");
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid_done");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid_done_release");
    run_op(EXT, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF, "after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_op_i = 1'b0; req_data_i = '0; req_mask_i = '0;
    req_cfg0_i = '0; req_cfg1_i = '0; req_cfg2_i = '0; req_cfg3_i = '0; req_cfg4_i = '0;
    kill_i = 1'b0; resp_ready_i = 1'b0;
    set_cfg(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    test_reset();
    test_identity();
    test_ordering();
    test_full_swap();
    test_switch_index();
    test_mask();
    test_backpressure();
    test_kill();
    test_reset_mid_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
